// File: rtl/call_return_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : call_return_stack                                          |
// | Description : Hardware return-address stack for the program counter.     |
// |               A call pushes pc_in+1, a return pops the top entry, and    |
// |               call+ret together replaces the top (tail call).            |
// |               Sticky overflow/underflow flags are provided for the       |
// |               control unit.                                              |
// | Ports       : clk, rst_n        clock, async active-low reset            |
// |               call, ret         decoded push / pop strobes               |
// |               pc_in[AW]         address of the executing call site       |
// |               clr_err           synchronous clear of sticky flags        |
// |               stk0, stk1[AW]    top and second entries (0 if invalid)    |
// |               count[CW]         number of valid entries                  |
// |               empty, full       decoded from the registered count        |
// |               overflow          sticky: push dropped while full          |
// |               underflow         sticky: pop requested while empty        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module call_return_stack #(
  parameter int AW    = 12,
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          call,
  input  logic          ret,
  input  logic [AW-1:0] pc_in,
  input  logic          clr_err,
  output logic [AW-1:0] stk0,
  output logic [AW-1:0] stk1,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  // Entry index width; DEPTH >= 2 keeps this at least one bit.
  localparam int IW = $clog2(DEPTH);

  logic [AW-1:0] r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_underflow;

  logic          w_empty;
  logic          w_full;
  logic [AW-1:0] w_push_val;
  logic [IW-1:0] w_top_idx;
  logic [IW-1:0] w_sec_idx;
  logic [IW-1:0] w_wr_idx;
  logic          w_wr_en;
  logic [CW-1:0] w_count_nxt;
  logic          w_ovf_set;
  logic          w_unf_set;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CW'(DEPTH));
  // Natural AW-bit wrap: 0xFFF + 1 -> 0x000.
  assign w_push_val = pc_in + AW'(1);
  // Indices are only used when the corresponding entry is valid, so any
  // wrap from subtracting past zero is harmless.
  assign w_top_idx  = IW'(r_count - CW'(1));
  assign w_sec_idx  = IW'(r_count - CW'(2));

  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_idx    = '0;
    w_count_nxt = r_count;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case ({call, ret})
      2'b10: begin
        if (!w_full) begin
          w_wr_en     = 1'b1;
          w_wr_idx    = IW'(r_count);
          w_count_nxt = r_count + CW'(1);
        end else begin
          w_ovf_set   = 1'b1;
        end
      end
      2'b01: begin
        if (!w_empty) begin
          // Popped entry keeps its data; it is masked by the count.
          w_count_nxt = r_count - CW'(1);
        end else begin
          w_unf_set   = 1'b1;
        end
      end
      2'b11: begin
        // Tail call: the return and the new call cancel in depth, so the
        // top is simply replaced. On an empty stack the pop half still
        // counts as an underflow but the push half is kept.
        w_wr_en = 1'b1;
        if (!w_empty) begin
          w_wr_idx    = w_top_idx;
        end else begin
          w_wr_idx    = '0;
          w_count_nxt = CW'(1);
          w_unf_set   = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[i] <= '0;
        end else if (w_wr_en && (w_wr_idx == IW'(i))) begin
          r_mem[i] <= w_push_val;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_nxt;
      // A new error on the same edge as clr_err takes priority.
      r_overflow  <= w_ovf_set | (r_overflow  & ~clr_err);
      r_underflow <= w_unf_set | (r_underflow & ~clr_err);
    end
  end

  // Reads depend only on registered state, so stk0 still shows the old
  // top during the cycle a return is asserted.
  assign stk0      = (r_count >= CW'(1)) ? r_mem[w_top_idx] : '0;
  assign stk1      = (r_count >= CW'(2)) ? r_mem[w_sec_idx] : '0;
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_call_return_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_call_return_stack                                       |
// | Description : Directed self-checking bench for call_return_stack.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_call_return_stack;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          call;
  logic          ret;
  logic [AW-1:0] pc_in;
  logic          clr_err;
  logic [AW-1:0] stk0;
  logic [AW-1:0] stk1;
  logic [CW-1:0] count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  int n_pass  = 0;
  int n_total = 0;

  call_return_stack #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .call      (call),
    .ret       (ret),
    .pc_in     (pc_in),
    .clr_err   (clr_err),
    .stk0      (stk0),
    .stk1      (stk1),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    call = 1'b0; ret = 1'b0; clr_err = 1'b0; pc_in = '0;
  endtask

  task automatic do_call(input logic [AW-1:0] pc);
    call = 1'b1; ret = 1'b0; pc_in = pc;
    tick();
    idle();
  endtask

  task automatic apply_reset();
    idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    apply_reset();
    n_total++; if (count !== 4'd0) $display("FAIL reset_count: got %0d want 0", count); else n_pass++;
    n_total++; if (empty !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty); else n_pass++;
    n_total++; if (full !== 1'b0) $display("FAIL reset_full: got %b want 0", full); else n_pass++;
    n_total++; if (stk0 !== 12'h000) $display("FAIL reset_stk0: got %h want 000", stk0); else n_pass++;
    n_total++; if (stk1 !== 12'h000) $display("FAIL reset_stk1: got %h want 000", stk1); else n_pass++;
    n_total++; if (overflow !== 1'b0 || underflow !== 1'b0)
      $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", overflow, underflow); else n_pass++;
  endtask

  task automatic test_nested();
    logic [AW-1:0] exp_top [3];
    exp_top[0] = 12'h400; exp_top[1] = 12'h121; exp_top[2] = 12'h011;
    apply_reset();
    do_call(12'h010);
    n_total++; if (stk0 !== 12'h011 || count !== 4'd1)
      $display("FAIL nest_first: got stk0=%h cnt=%0d want 011 1", stk0, count); else n_pass++;
    do_call(12'h120);
    do_call(12'h3FF);
    n_total++; if (stk0 !== 12'h400) $display("FAIL nest_stk0: got %h want 400", stk0); else n_pass++;
    n_total++; if (stk1 !== 12'h121) $display("FAIL nest_stk1: got %h want 121", stk1); else n_pass++;
    n_total++; if (count !== 4'd3) $display("FAIL nest_count: got %0d want 3", count); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      ret = 1'b1;
      #1;
      n_total++; if (stk0 !== exp_top[i])
        $display("FAIL nest_ret%0d_stk0: got %h want %h", i, stk0, exp_top[i]); else n_pass++;
      tick();
      idle();
    end
    n_total++; if (empty !== 1'b1 || stk0 !== 12'h000)
      $display("FAIL nest_empty: got empty=%b stk0=%h want 1 000", empty, stk0); else n_pass++;
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < DEPTH; i++) do_call(12'(i));
    n_total++; if (full !== 1'b1 || count !== 4'd8)
      $display("FAIL ovf_full: got full=%b cnt=%0d want 1 8", full, count); else n_pass++;
    n_total++; if (stk0 !== 12'h008 || stk1 !== 12'h007)
      $display("FAIL ovf_top: got stk0=%h stk1=%h want 008 007", stk0, stk1); else n_pass++;
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_pre: got %b want 0", overflow); else n_pass++;
    do_call(12'h050);
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else n_pass++;
    n_total++; if (stk0 !== 12'h008 || count !== 4'd8)
      $display("FAIL ovf_dropped: got stk0=%h cnt=%0d want 008 8", stk0, count); else n_pass++;
    tick();
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    clr_err = 1'b1; tick(); idle();
    n_total++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
    // Tail call while full: replace the top, no flag.
    call = 1'b1; ret = 1'b1; pc_in = 12'h060; tick(); idle();
    n_total++; if (stk0 !== 12'h061 || count !== 4'd8 || overflow !== 1'b0)
      $display("FAIL ovf_tail: got stk0=%h cnt=%0d ovf=%b want 061 8 0", stk0, count, overflow); else n_pass++;
    // Error and clear on the same edge: error wins.
    call = 1'b1; clr_err = 1'b1; pc_in = 12'h070; tick(); idle();
    n_total++; if (overflow !== 1'b1) $display("FAIL ovf_clr_race: got %b want 1", overflow); else n_pass++;
  endtask

  task automatic test_underflow();
    apply_reset();
    ret = 1'b1; tick(); idle();
    n_total++; if (underflow !== 1'b1 || count !== 4'd0)
      $display("FAIL unf_flag: got unf=%b cnt=%0d want 1 0", underflow, count); else n_pass++;
    call = 1'b1; ret = 1'b1; pc_in = 12'h0A0; tick(); idle();
    n_total++; if (count !== 4'd1 || stk0 !== 12'h0A1)
      $display("FAIL unf_callret_empty: got cnt=%0d stk0=%h want 1 0a1", count, stk0); else n_pass++;
    clr_err = 1'b1; tick(); idle();
    n_total++; if (underflow !== 1'b0) $display("FAIL unf_clear: got %b want 0", underflow); else n_pass++;
    call = 1'b1; ret = 1'b1; pc_in = 12'h200; tick(); idle();
    n_total++; if (count !== 4'd1 || stk0 !== 12'h201 || underflow !== 1'b0)
      $display("FAIL unf_tail: got cnt=%0d stk0=%h unf=%b want 1 201 0", count, stk0, underflow); else n_pass++;
    // pc_in changes without call must not matter; pop leaves stale data masked.
    pc_in = 12'h555; ret = 1'b1; tick(); idle();
    n_total++; if (count !== 4'd0 || stk0 !== 12'h000 || empty !== 1'b1)
      $display("FAIL unf_pop_mask: got cnt=%0d stk0=%h empty=%b want 0 000 1", count, stk0, empty); else n_pass++;
  endtask

  task automatic test_wrap_async_reset();
    apply_reset();
    do_call(12'hFFF);
    n_total++; if (stk0 !== 12'h000 || count !== 4'd1)
      $display("FAIL wrap: got stk0=%h cnt=%0d want 000 1", stk0, count); else n_pass++;
    for (int i = 0; i < 4; i++) do_call(12'h100 + 12'(i));
    n_total++; if (count !== 4'd5 || stk0 !== 12'h104)
      $display("FAIL wrap_fill: got cnt=%0d stk0=%h want 5 104", count, stk0); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (count !== 4'd0 || stk0 !== 12'h000 || empty !== 1'b1)
      $display("FAIL async_reset: got cnt=%0d stk0=%h empty=%b want 0 000 1", count, stk0, empty); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
    n_total++; if (stk1 !== 12'h000 || count !== 4'd0)
      $display("FAIL async_release: got stk1=%h cnt=%0d want 000 0", stk1, count); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    test_reset();
    test_nested();
    test_overflow();
    test_underflow();
    test_wrap_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
